// File: rtl/microcode_dispatch_pkg.sv
// Shared FISC defines for the microcode dispatcher: opcode width and dispatch FSM states.
package microcode_dispatch_pkg;

  localparam int unsigned FISC_OPCODE_W = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LAT  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/mc_dispatch_fifo.sv
// Two-entry opcode FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
module mc_dispatch_fifo #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         push_ok;
  logic         pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/microcode_dispatch.sv
// Issues queued microcoded opcodes to the microcode unit one segment at a time,
// waiting out a fixed start latency and bounding each run with a timeout.
module microcode_dispatch
  import microcode_dispatch_pkg::*;
#(
  parameter int unsigned OPCODE_W = FISC_OPCODE_W,
  parameter int unsigned LATENCY  = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] instr_opcode,
  output logic                instr_ready,
  output logic                mc_sos,
  output logic [OPCODE_W-1:0] mc_opcode,
  input  logic                mc_eos,
  output logic                seq_done,
  output logic                busy,
  input  logic                err_clr,
  output logic                timeout_err
);

  localparam int unsigned LAT_W = $clog2(LATENCY + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  dispatch_state_e     state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                sos_q, sos_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                push;
  logic                pop;
  logic [OPCODE_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_nonempty_d;

  assign instr_ready = ~fifo_full;
  assign push        = instr_valid && instr_ready;

  mc_dispatch_fifo #(.W(OPCODE_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (instr_opcode),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    tmo_d   = tmo_q;
    sos_d   = 1'b0;
    opc_d   = opc_q;
    done_d  = 1'b0;
    err_d   = err_q;
    pop     = 1'b0;
    // Clear is applied first so a timeout set later in this block wins the race.
    if (err_clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sos_d   = 1'b1;
          opc_d   = fifo_dout;
          lat_d   = LAT_LOAD;
          state_d = LAT;
        end
      end
      LAT: begin
        if (lat_q != '0) lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          state_d = RUN;
          tmo_d   = '0;
        end
      end
      RUN: begin
        if (mc_eos) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (tmo_q >= TMO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // busy is registered, so it is built from next-cycle state and FIFO occupancy.
    fifo_nonempty_d = push || (!fifo_empty && !pop) || (fifo_full && pop);
    busy_d          = (state_d != IDLE) || fifo_nonempty_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      tmo_q   <= '0;
      sos_q   <= 1'b0;
      opc_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tmo_q   <= tmo_d;
      sos_q   <= sos_d;
      opc_q   <= opc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign mc_sos      = sos_q;
  assign mc_opcode   = opc_q;
  assign seq_done    = done_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_microcode_dispatch.sv
// Directed bench for microcode_dispatch: a cycle table for a single segment plus
// hand-written sequences for back-pressure, timeout, eos masking, reset and error clear.
module tb_microcode_dispatch;

  logic clk;
  logic rst_n;

  logic        a_valid, a_ready, a_sos, a_eos, a_done, a_busy, a_err_clr, a_err;
  logic [10:0] a_opcode, a_mc_opcode;
  logic        b_valid, b_ready, b_sos, b_eos, b_done, b_busy, b_err_clr, b_err;
  logic [10:0] b_opcode, b_mc_opcode;

  microcode_dispatch #(.LATENCY(3), .TIMEOUT(64)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (a_valid),
    .instr_opcode (a_opcode),
    .instr_ready  (a_ready),
    .mc_sos       (a_sos),
    .mc_opcode    (a_mc_opcode),
    .mc_eos       (a_eos),
    .seq_done     (a_done),
    .busy         (a_busy),
    .err_clr      (a_err_clr),
    .timeout_err  (a_err)
  );

  microcode_dispatch #(.LATENCY(3), .TIMEOUT(8)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (b_valid),
    .instr_opcode (b_opcode),
    .instr_ready  (b_ready),
    .mc_sos       (b_sos),
    .mc_opcode    (b_mc_opcode),
    .mc_eos       (b_eos),
    .seq_done     (b_done),
    .busy         (b_busy),
    .err_clr      (b_err_clr),
    .timeout_err  (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [10:0] op;
    logic        eos;
    logic        rdy;
    logic        sos;
    logic [10:0] mop;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t        tbl [9];
  int          checks   = 0;
  int          failures = 0;
  int          age      = 1000;
  int          eos_len  = 0;
  bit          eos_in_lat = 1'b0;
  int          done_cnt = 0;
  logic [10:0] issued [$];
  logic [10:0] ops [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance dut_a one cycle; age counts cycles since the last observed mc_sos
  // (age 0..2 = latency, age 3 = first RUN cycle) and steers mc_eos.
  task automatic step_a();
    tick();
    if (a_sos) begin
      issued.push_back(a_mc_opcode);
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
    if (a_done) done_cnt++;
    a_eos = (eos_in_lat && age < 3) || (age == eos_len + 3);
  endtask

  task automatic wait_sos_b(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (b_sos) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int done_age, first_sos_tick, acc103_tick, low_tick, idx;
    bit rdy;

    rst_n = 1'b0;
    a_valid = 0; a_opcode = '0; a_eos = 0; a_err_clr = 0;
    b_valid = 0; b_opcode = '0; b_eos = 0; b_err_clr = 0;
    ops[0] = 11'h101; ops[1] = 11'h102; ops[2] = 11'h103;

    // Reset state
    repeat (2) tick();
    check("rst.sos",   a_sos, 0);
    check("rst.mcop",  a_mc_opcode, 0);
    check("rst.done",  a_done, 0);
    check("rst.err",   a_err, 0);
    check("rst.b_err", b_err, 0);
    rst_n = 1'b1;
    tick();
    check("rst.ready", a_ready, 1);
    check("rst.busy",  a_busy, 0);
    check("rst.b_ready", b_ready, 1);
    check("rst.b_busy",  b_busy, 0);

    // Scenario 1: single segment 0x2A3, eos on the 2nd RUN cycle
    tbl[0] = '{1'b1, 11'h2A3, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 11'h2A3, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h2A3, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h2A3, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h2A3, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h2A3, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 11'h000, 1'b1, 1'b1, 1'b0, 11'h2A3, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h2A3, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 11'h2A3, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      a_valid  = tbl[i].valid;
      a_opcode = tbl[i].op;
      a_eos    = tbl[i].eos;
      tick();
      check($sformatf("s1[%0d].ready", i), a_ready, tbl[i].rdy);
      check($sformatf("s1[%0d].sos", i),   a_sos, tbl[i].sos);
      check($sformatf("s1[%0d].mcop", i),  a_mc_opcode, tbl[i].mop);
      check($sformatf("s1[%0d].done", i),  a_done, tbl[i].done);
      check($sformatf("s1[%0d].busy", i),  a_busy, tbl[i].busy);
      check($sformatf("s1[%0d].err", i),   a_err, 0);
    end
    a_valid = 0; a_eos = 0;

    // Scenario 4: eos held high through latency, completion only after first RUN cycle
    eos_in_lat = 1'b1; eos_len = 0; done_age = -1;
    a_valid = 1; a_opcode = 11'h3C4;
    step_a();
    a_valid = 0;
    for (int k = 0; k < 20; k++) begin
      step_a();
      if (a_done && done_age < 0) done_age = age;
    end
    check("s4.done_age", done_age, 4);
    check("s4.issued", (issued.size() == 1) ? 32'(issued[0]) : 32'hFFFF_FFFF, 11'h3C4);
    check("s4.busy_end", a_busy, 0);
    eos_in_lat = 1'b0;

    // Scenario 2: back-pressure with three back-to-back pushes
    issued.delete(); done_cnt = 0; eos_len = 10;
    idx = 0; first_sos_tick = -1; acc103_tick = -1; low_tick = -1;
    for (int t = 0; t < 300 && done_cnt < 3; t++) begin
      if (idx < 3) begin
        a_valid = 1; a_opcode = ops[idx];
      end else begin
        a_valid = 0;
      end
      rdy = a_ready;
      step_a();
      if (a_valid && rdy) begin
        if (idx == 2) acc103_tick = t;
        idx++;
      end
      if (!a_ready && low_tick < 0) low_tick = t;
      if (a_sos && first_sos_tick < 0) first_sos_tick = t;
    end
    a_valid = 0;
    step_a(); step_a();
    check("s2.first_sos_tick", first_sos_tick, 1);
    check("s2.acc103_tick", acc103_tick, 2);
    check("s2.ready_low_tick", low_tick, 2);
    check("s2.done_cnt", done_cnt, 3);
    check("s2.issue_cnt", issued.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("s2.issue%0d", i),
            (i < issued.size()) ? 32'(issued[i]) : 32'hFFFF_FFFF, ops[i]);
    check("s2.busy_end", a_busy, 0);

    // Scenario 5: reset in RUN with one opcode still queued
    issued.delete(); done_cnt = 0; eos_len = 20;
    a_valid = 1; a_opcode = 11'h055;
    step_a();
    a_opcode = 11'h066;
    step_a();
    a_valid = 0;
    for (int k = 0; k < 20 && age != 5; k++) step_a();
    check("s5.in_run", age, 5);
    check("s5.busy_pre", a_busy, 1);
    rst_n = 1'b0;
    tick();
    check("s5.sos",   a_sos, 0);
    check("s5.mcop",  a_mc_opcode, 0);
    check("s5.done",  a_done, 0);
    check("s5.busy",  a_busy, 0);
    check("s5.err",   a_err, 0);
    check("s5.ready", a_ready, 1);
    rst_n = 1'b1;
    age = 1000;
    for (int k = 0; k < 30; k++) step_a();
    check("s5.issue_cnt", issued.size(), 1);
    check("s5.done_cnt", done_cnt, 0);

    // Scenario 3: timeout after exactly 8 RUN cycles (TIMEOUT=8)
    b_valid = 1; b_opcode = 11'h0B1;
    tick();
    b_valid = 0;
    wait_sos_b(ok);
    check("s3.sos_seen", ok, 1);
    check("s3.mcop", b_mc_opcode, 11'h0B1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) begin
        check("s3.err_before", b_err, 0);
        check("s3.done_before", b_done, 0);
      end
      if (k == 11) begin
        check("s3.err_set", b_err, 1);
        check("s3.done_pulse", b_done, 1);
      end
      if (k == 12) begin
        check("s3.done_single", b_done, 0);
        check("s3.err_sticky", b_err, 1);
        check("s3.busy_idle", b_busy, 0);
      end
    end
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    check("s3.err_cleared", b_err, 0);

    // Scenario 6: next opcode still dispatched; clear races a new timeout
    b_valid = 1; b_opcode = 11'h0B2;
    tick();
    b_valid = 0;
    wait_sos_b(ok);
    check("s6.sos_seen", ok, 1);
    check("s6.mcop", b_mc_opcode, 11'h0B2);
    repeat (10) tick();
    check("s6.err_pre", b_err, 0);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    check("s6.race_err", b_err, 1);
    check("s6.race_done", b_done, 1);
    tick();
    check("s6.err_hold", b_err, 1);
    b_err_clr = 1;
    tick();
    b_err_clr = 0;
    check("s6.err_clear", b_err, 0);
    check("s6.busy_end", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microcode_dispatch.md
MICROCODE_DISPATCH -- requirements
Module: microcode_dispatch

Interface
REQ-001 Parameters SHALL be: OPCODE_W, default 11, opcode width equal to the shared R-format opcode size; LATENCY, default 3, cycles from mc_sos to the first meaningful mc_eos sample; TIMEOUT, default 64, maximum cycles allowed in RUN.
REQ-002 Ports SHALL be, in order: clk in 1 clock; rst_n in 1 reset, synchronous, active-low; instr_valid in 1 upstream opcode valid; instr_opcode in OPCODE_W microcoded opcode; instr_ready out 1 dispatcher can accept; mc_sos out 1 start-of-segment pulse to the microcode unit; mc_opcode out OPCODE_W segment opcode to the microcode unit; mc_eos in 1 LSB of the microcode control word; seq_done out 1 one-cycle pulse when a segment completes; busy out 1 work pending or in progress; err_clr in 1 clears the error flag; timeout_err out 1 sticky timeout flag.

Function
REQ-003 Input transfer SHALL occur on any clock edge where instr_valid and instr_ready are both 1; the opcode SHALL be pushed into a 2-entry FIFO.
REQ-004 instr_ready SHALL equal NOT FIFO-full (combinational); upstream SHALL hold instr_opcode stable while valid and not ready.
REQ-005 FSM states SHALL be: IDLE, LAT, RUN, DONE.
REQ-006 IDLE with FIFO non-empty: at the clock edge, pop the head into mc_opcode, assert mc_sos, load the latency counter with LATENCY, and go to LAT.
REQ-007 mc_sos SHALL be high for exactly one cycle per segment; mc_opcode SHALL hold its value until the next issue.
REQ-008 An opcode accepted into an empty FIFO at edge N SHALL produce mc_sos high in the cycle following edge N+1, a latency of 2 edges.
REQ-009 LAT: mc_eos SHALL be ignored; the counter decrements each cycle; when it equals 1, transition to RUN and clear the timeout counter.
REQ-010 RUN: if mc_eos is 1, go to DONE and pulse seq_done for 1 cycle. Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1 without eos, set timeout_err, go to DONE, and pulse seq_done.
REQ-011 DONE SHALL last exactly 1 cycle, covering the microcode finish cycle, then return to IDLE; the next issue is earliest 1 cycle later.
REQ-012 A push and a pop on the same edge SHALL leave the occupancy unchanged; a push when full SHALL be impossible because ready is low.
REQ-013 FIFO pointers SHALL be 1 bit with wrap-around; occupancy SHALL be a 2-bit count in the range 0..2.
REQ-014 busy SHALL be 1 when state is not IDLE or the FIFO is non-empty, and 0 otherwise.
REQ-015 timeout_err SHALL be sticky until err_clr=1 at a clock edge. If err_clr and a new timeout occur on the same edge, the set SHALL win.
REQ-016 Counter widths SHALL be clog2(LATENCY+1) and clog2(TIMEOUT+1); no counter SHALL wrap.

Reset
REQ-017 On rst_n=0 at a clock edge: state IDLE, FIFO empty, mc_sos 0, mc_opcode 0, seq_done 0, timeout_err 0, counters 0.
REQ-018 Immediately after reset, instr_ready SHALL be 1 and busy SHALL be 0.
REQ-019 Reset asserted mid-segment SHALL abort the segment with no seq_done pulse; queued opcodes SHALL be discarded.

Structure
REQ-020 The dispatch state enum and the OPCODE_W default SHALL live in the shared FISC defines package; LATENCY and TIMEOUT SHALL stay module parameters.
REQ-021 The 2-entry FIFO SHALL be a sub-module named mc_dispatch_fifo (push, pop, din, dout, full, empty).
REQ-022 All outputs except instr_ready SHALL be registered.

Verification
REQ-023 Scenario 1, single segment: push 0x2A3, with mc_eos driven to 1 on the 2nd RUN cycle -> mc_sos one cycle with mc_opcode=0x2A3; seq_done a single pulse; busy returns to 0 after DONE.
REQ-024 Scenario 2, back-pressure: 3 back-to-back pushes (0x101, 0x102, 0x103) with mc_eos held 0 for 10 RUN cycles -> instr_ready low after 2 entries, 0x103 accepted only after the first pop, issue order 0x101, 0x102, 0x103.
REQ-025 Scenario 3, timeout: TIMEOUT=8, mc_eos never asserted -> timeout_err=1 after exactly 8 RUN cycles, seq_done pulsed, next opcode still dispatched.
REQ-026 Scenario 4, eos ignored during latency: mc_eos=1 throughout LAT -> no early completion, earliest seq_done in the first RUN cycle.
REQ-027 Scenario 5, mid-run reset: rst_n=0 while in RUN with 1 queued opcode -> all outputs at reset values, no seq_done, no later issue of the queued opcode.
REQ-028 Scenario 6, error clear race: err_clr pulsed on the same edge as a new timeout -> timeout_err remains 1; a later err_clr clears it to 0.
